// File: rtl/rx_char_display.sv
// rx_char_display: receive-side character memory and multiplexed 7-segment scan.
// Ports: clk, reset (async, active-high), rx_data/rx_valid/rx_ferror/rx_perror
//   from the UART receiver, mode (0 shift, 1 cursor), clear; outputs an/seg/dp
//   (all active-low, an[0] rightmost) and char_count (saturating at 255).
module rx_char_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int DATA_W         = 4,
  parameter int REFRESH_CYCLES = 16384,
  parameter int BLANK_CYCLES   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_ferror,
  input  logic                  rx_perror,
  input  logic                  mode,
  input  logic                  clear,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [7:0]            char_count
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  // Entry layout: {used, err, data[3:0]}
  logic [5:0]    mem [NUM_DIGITS];
  logic [IW-1:0] cursor;
  logic          valid_q;
  logic          accept;
  logic [5:0]    new_entry;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  // VALID is a level; only its rising edge takes a character.
  assign accept    = rx_valid & ~valid_q;
  assign new_entry = {1'b1, rx_ferror | rx_perror, rx_data[3:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        mem[i] <= '0;
      cursor     <= '0;
      char_count <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= rx_valid;
      if (clear) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          mem[i] <= '0;
        cursor     <= '0;
        char_count <= '0;
      end else if (accept) begin
        if (char_count != 8'hFF)
          char_count <= char_count + 8'd1;
        if (mode) begin
          mem[cursor] <= new_entry;
          cursor <= (cursor == IDX_LAST) ? '0 : cursor + IW'(1);
        end else begin
          for (int i = NUM_DIGITS - 1; i > 0; i--)
            mem[i] <= mem[i-1];
          mem[0] <= new_entry;
        end
      end
    end
  end

  function automatic logic [7:0] decode(input logic [5:0] e);
    logic [6:0] s;
    if (!e[5]) begin
      return {7'h7F, 1'b1};
    end
    if (e[4]) begin
      return {7'b0110000, 1'b0};
    end
    unique case (e[3:0])
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
    endcase
    return {s, 1'b1};
  endfunction

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    idx_nxt = idx;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
    // Anodes are registered from the next count so they line up with cnt.
    an_nxt = '1;
    if (cnt_nxt >= CNT_BLANK)
      an_nxt[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      an  <= an_nxt;
      // Latch the pattern at slot start, while anodes are still blanked.
      if (cnt == '0)
        {seg, dp} <= decode(mem[idx]);
    end
  end

endmodule

// File: tb/tb_rx_char_display.sv
// tb_rx_char_display: random and directed stimulus against a queue-based
// reference model; a monitor checks every cycle and every displayed slot.
module tb_rx_char_display;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int R  = 32;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ferror = 1'b0;
  logic          rx_perror = 1'b0;
  logic          mode = 1'b0;
  logic          clear = 1'b0;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic [7:0]    char_count;

  int checks = 0;
  int errors = 0;

  rx_char_display #(
    .NUM_DIGITS(N),
    .DATA_W(DW),
    .REFRESH_CYCLES(R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ferror(rx_ferror),
    .rx_perror(rx_perror),
    .mode(mode),
    .clear(clear),
    .an(an),
    .seg(seg),
    .dp(dp),
    .char_count(char_count)
  );

  always #5 clk = ~clk;

  // Lit segments per hex glyph, by segment letter.
  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg",
                      "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg",
                      "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] hex_seg(int v);
    logic [6:0] s;
    string t;
    s = 7'h7F;
    t = lit[v];
    for (int j = 0; j < t.len(); j++) begin
      int p;
      p = int'(t[j]) - 97;
      s[6-p] = 1'b0;
    end
    return s;
  endfunction

  typedef struct { bit used; bit err; bit [3:0] d; } ent_t;
  typedef struct { int idx; logic [6:0] seg; logic dp; } exp_t;

  ent_t mem_m[$];
  exp_t sbq[$];
  exp_t cur_exp;
  bit   have_cur = 1'b0;
  int   e = 0;
  int   cnt_m = 0;
  int   cur_m = 0;
  bit   prev_v = 1'b0;

  logic [6:0] shown_seg [N];
  logic       shown_dp [N];

  function automatic void model_clear();
    mem_m.delete();
    for (int i = 0; i < N; i++)
      mem_m.push_back('{1'b0, 1'b0, 4'h0});
    cur_m = 0;
    cnt_m = 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: e counts functional edges since reset release.
  always @(posedge clk) begin : model
    ent_t en;
    exp_t x;
    bit   acc;
    if (reset) begin
      e = 0;
      prev_v = 1'b0;
      model_clear();
      sbq.delete();
    end else begin
      if (e % R == 0) begin
        en = mem_m[(e / R) % N];
        x.idx = (e / R) % N;
        if (!en.used) begin
          x.seg = 7'h7F;
          x.dp  = 1'b1;
        end else if (en.err) begin
          x.seg = hex_seg(14);
          x.dp  = 1'b0;
        end else begin
          x.seg = hex_seg(int'(en.d));
          x.dp  = 1'b1;
        end
        sbq.push_back(x);
      end
      e++;
      acc = rx_valid && !prev_v;
      prev_v = rx_valid;
      if (clear) begin
        model_clear();
      end else if (acc) begin
        en = '{1'b1, rx_ferror | rx_perror, rx_data[3:0]};
        if (cnt_m < 255) cnt_m++;
        if (!mode) begin
          mem_m.push_front(en);
          void'(mem_m.pop_back());
        end else begin
          mem_m[cur_m] = en;
          cur_m = (cur_m + 1) % N;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [N-1:0] ea;
    logic [N-1:0] slot_an;
    int ci;
    int ii;
    if (reset) begin
      have_cur = 1'b0;
    end else begin
      ci = e % R;
      ii = (e / R) % N;
      ea = '1;
      if (ci >= B) ea[ii] = 1'b0;
      chk("an", 32'(an), 32'(ea));
      chk("char_count", 32'(char_count), 32'(cnt_m));
      if (an != '1) begin
        if (!have_cur) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: slot active, nothing expected (t=%0t)", $time);
          end else begin
            cur_exp = sbq.pop_front();
            have_cur = 1'b1;
            slot_an = '1;
            slot_an[cur_exp.idx] = 1'b0;
            chk("slot_an", 32'(an), 32'(slot_an));
          end
        end
        if (have_cur) begin
          chk("seg", 32'(seg), 32'(cur_exp.seg));
          chk("dp", 32'(dp), 32'(cur_exp.dp));
          shown_seg[cur_exp.idx] = seg;
          shown_dp[cur_exp.idx] = dp;
        end
      end else begin
        have_cur = 1'b0;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(int d, bit pe, bit fe, int hold, int gap, bit clr);
    rx_data = DW'(d);
    rx_perror = pe;
    rx_ferror = fe;
    rx_valid = 1'b1;
    clear = clr;
    tick(1);
    clear = 1'b0;
    if (hold > 1) tick(hold - 1);
    rx_valid = 1'b0;
    rx_perror = 1'b0;
    rx_ferror = 1'b0;
    tick(gap);
  endtask

  task automatic chk_shown(string name, int i, logic [6:0] s, logic d);
    chk({name, "_seg"}, 32'(shown_seg[i]), 32'(s));
    chk({name, "_dp"}, 32'(shown_dp[i]), 32'(d));
  endtask

  task automatic chk_blank(string name);
    for (int i = 0; i < N; i++)
      chk_shown(name, i, 7'h7F, 1'b1);
  endtask

  initial begin
    int w;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    tick(200);
    chk_blank("idle");

    mode = 1'b0;
    for (int v = 1; v <= 5; v++)
      send(v, 1'b0, 1'b0, 10, 3, 1'b0);
    tick(200);
    chk("count_shift", 32'(char_count), 32'd5);
    chk_shown("shift3", 3, 7'h12, 1'b1);
    chk_shown("shift2", 2, 7'h06, 1'b1);
    chk_shown("shift1", 1, 7'h4C, 1'b1);
    chk_shown("shift0", 0, 7'h24, 1'b1);

    mode = 1'b1;
    for (int v = 10; v <= 14; v++)
      send(v, 1'b0, 1'b0, 10, 3, 1'b0);
    tick(200);
    chk("count_cursor", 32'(char_count), 32'd10);
    chk_shown("cur0", 0, 7'h30, 1'b1);
    chk_shown("cur1", 1, 7'h60, 1'b1);
    chk_shown("cur2", 2, 7'h31, 1'b1);
    chk_shown("cur3", 3, 7'h42, 1'b1);

    send(7, 1'b1, 1'b0, 5, 3, 1'b0);
    tick(200);
    chk("count_err", 32'(char_count), 32'd11);
    chk_shown("err1", 1, 7'h30, 1'b0);

    rx_data = 4'h3;
    rx_valid = 1'b1;
    tick(500);
    rx_valid = 1'b0;
    tick(2);
    chk("count_held", 32'(char_count), 32'd12);
    send(9, 1'b0, 1'b0, 20, 3, 1'b1);
    chk("count_clear", 32'(char_count), 32'd0);
    tick(200);
    chk_blank("cleared");

    mode = 1'b0;
    for (int i = 0; i < 260; i++)
      send(i % 16, 1'b0, 1'b0, 1, 1, 1'b0);
    chk("count_sat", 32'(char_count), 32'd255);

    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(5) == 0) mode = 1'($urandom_range(1));
      if ($urandom_range(19) == 0) begin
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
      end
      send(int'($urandom_range(15)), $urandom_range(7) == 0,
           $urandom_range(7) == 0, int'($urandom_range(12, 1)),
           int'($urandom_range(6, 1)), $urandom_range(14) == 0);
    end

    for (int v = 0; v < 3; v++)
      send(v + 4, 1'b0, 1'b0, 3, 2, 1'b0);
    w = 0;
    while (an[2] !== 1'b0 && w < 400) begin
      tick(1);
      w++;
    end
    if (w >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_an2: an=%b never selected digit 2", an);
    end
    tick(5);
    reset = 1'b1;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_count", 32'(char_count), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(200);
    chk_blank("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
